// File: rtl/daughter_power_sequencer.sv
// Sequences daughterboard rail power one rail at a time: scan pointer walks the
// rails, powering up with a settle delay and powering down after a drive drain delay.
module daughter_power_sequencer #(
    parameter int          NUM_CH        = 16,
    parameter logic [15:0] SETTLE_CYCLES = 16'd50000,
    parameter logic [15:0] DRAIN_CYCLES  = 16'd1000,
    localparam int         PW            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] power_req_i,
    input  logic [NUM_CH-1:0] drive_req_i,
    output logic [NUM_CH-1:0] power_o,
    output logic [NUM_CH-1:0] drive_o,
    output logic              busy_o,
    output logic [PW-1:0]     cur_ch_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    localparam logic [PW-1:0] LAST_CH = PW'(NUM_CH - 1);

    state_t            state;
    state_t            state_n;
    logic [PW-1:0]     p;
    logic [PW-1:0]     p_n;
    logic [PW-1:0]     p_inc;
    logic [15:0]       cnt;
    logic [15:0]       cnt_n;
    logic [NUM_CH-1:0] settled;
    logic [NUM_CH-1:0] settled_n;
    logic [NUM_CH-1:0] power_n;

    assign p_inc = (p == LAST_CH) ? '0 : p + 1'b1;

    // A rail change is never abandoned mid-delay; an opposite request is
    // picked up when the pointer comes round to that rail again.
    always_comb begin
        state_n   = state;
        p_n       = p;
        cnt_n     = cnt;
        power_n   = power_o;
        settled_n = settled;
        case (state)
            IDLE: begin
                if (power_req_i[p] && !power_o[p]) begin
                    power_n[p] = 1'b1;
                    cnt_n      = SETTLE_CYCLES - 16'd1;
                    state_n    = SETTLE;
                end else if (!power_req_i[p] && power_o[p]) begin
                    settled_n[p] = 1'b0;
                    cnt_n        = DRAIN_CYCLES - 16'd1;
                    state_n      = DRAIN;
                end else begin
                    p_n = p_inc;
                end
            end
            SETTLE: begin
                if (cnt == 16'd0) begin
                    settled_n[p] = 1'b1;
                    p_n          = p_inc;
                    state_n      = IDLE;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            DRAIN: begin
                if (cnt == 16'd0) begin
                    power_n[p] = 1'b0;
                    p_n        = p_inc;
                    state_n    = IDLE;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            p       <= '0;
            cnt     <= 16'd0;
            power_o <= '0;
            settled <= '0;
        end else begin
            state   <= state_n;
            p       <= p_n;
            cnt     <= cnt_n;
            power_o <= power_n;
            settled <= settled_n;
        end
    end

    // Drive follows the settled flags one edge late, so it lags settle
    // completion and drops one edge after a drain begins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drive_o <= '0;
        end else begin
            drive_o <= drive_req_i & settled;
        end
    end

    assign busy_o   = (state == SETTLE) || (state == DRAIN);
    assign cur_ch_o = p;

endmodule

// File: tb/tb_daughter_power_sequencer.sv
// Directed bench for daughter_power_sequencer with a queue of expected values
// that is pushed as stimulus is applied and popped at each sampling point.
module tb_daughter_power_sequencer;

    localparam int NCH = 16;
    localparam logic [15:0] S = 16'd8;
    localparam logic [15:0] D = 16'd4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NCH-1:0]  power_req;
    logic [NCH-1:0]  drive_req;
    logic [NCH-1:0]  power;
    logic [NCH-1:0]  drive;
    logic            busy;
    logic [3:0]      cur_ch;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    daughter_power_sequencer #(
        .NUM_CH       (NCH),
        .SETTLE_CYCLES(S),
        .DRAIN_CYCLES (D)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .power_req_i(power_req),
        .drive_req_i(drive_req),
        .power_o    (power),
        .drive_o    (drive),
        .busy_o     (busy),
        .cur_ch_o   (cur_ch)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [NCH-1:0] pr, input logic [NCH-1:0] dr);
        power_req = pr;
        drive_req = dr;
    endtask

    task automatic expectPush(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("[TB] FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                bad++;
                $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus('0, '0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic waitBusy(input logic lvl, input int maxc, output int took);
        took = -1;
        for (int i = 1; i <= maxc && took < 0; i++) begin
            tick();
            if (busy === lvl) took = i;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int took;
        int rise0;
        int rise15;
        int last_rise;
        int min_gap;
        int max_new;
        int nz;
        int saw_wrap;
        logic [NCH-1:0] prev;
        logic [NCH-1:0] newb;

        // Reset state
        rst = 1'b1;
        applyStimulus('0, '0);
        tick();
        tick();
        expectPush("rst_power", 32'h0);  checkOutput(32'(power));
        expectPush("rst_drive", 32'h0);  checkOutput(32'(drive));
        expectPush("rst_busy", 32'h0);   checkOutput(32'(busy));
        expectPush("rst_cur_ch", 32'h0); checkOutput(32'(cur_ch));

        // Single rail turn-on from reset
        rst = 1'b0;
        applyStimulus(16'h0001, 16'h0001);
        tick();
        expectPush("t1_power_first_edge", 32'h0001); checkOutput(32'(power));
        expectPush("t1_cur_ch_hold", 32'h0);         checkOutput(32'(cur_ch));
        for (int i = 0; i < 8; i++) begin
            expectPush("t1_busy_settle", 32'h1);
            checkOutput(32'(busy));
            tick();
        end
        expectPush("t1_busy_end", 32'h0);     checkOutput(32'(busy));
        expectPush("t1_drive_early", 32'h0);  checkOutput(32'(drive));
        expectPush("t1_cur_ch_adv", 32'h1);   checkOutput(32'(cur_ch));
        tick();
        expectPush("t1_drive_on", 32'h0001);  checkOutput(32'(drive));

        // Two rails requested together are powered strictly one after another
        doReset();
        applyStimulus(16'h8001, 16'h0000);
        expectPush("t2_rise0_cycle", 32'd1);
        expectPush("t2_rise15_cycle", 32'd24);
        expectPush("t2_max_new_bits", 32'd1);
        expectPush("t2_gap_ge_settle", 32'd1);
        expectPush("t2_power_final", 32'h8001);
        rise0 = -1; rise15 = -1; last_rise = -1; min_gap = 1000; max_new = 0;
        prev = power;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            tick();
            newb = power & ~prev;
            if (newb != '0) begin
                if ($countones(newb) > max_new) max_new = $countones(newb);
                if (last_rise >= 0 && (cyc - last_rise) < min_gap) min_gap = cyc - last_rise;
                last_rise = cyc;
            end
            if (newb[0])  rise0 = cyc;
            if (newb[15]) rise15 = cyc;
            prev = power;
        end
        checkOutput(32'(rise0));
        checkOutput(32'(rise15));
        checkOutput(32'(max_new));
        checkOutput(32'(min_gap >= 9));
        checkOutput(32'(power));

        // Turn-off of a driven rail
        doReset();
        applyStimulus(16'h0008, 16'h0008);
        took = -1;
        for (int i = 1; i <= 40 && took < 0; i++) begin
            tick();
            if (drive[3] === 1'b1) took = i;
        end
        expectPush("t3_drive_on_cycle", 32'd13); checkOutput(32'(took));
        applyStimulus(16'h0000, 16'h0008);
        waitBusy(1'b1, 40, took);
        expectPush("t3_drain_entry_cycle", 32'd15); checkOutput(32'(took));
        expectPush("t3_power_at_entry", 32'h0008);  checkOutput(32'(power));
        tick();
        expectPush("t3_drive_dropped", 32'h0000);   checkOutput(32'(drive));
        expectPush("t3_power_e1", 32'h0008);        checkOutput(32'(power));
        tick();
        tick();
        expectPush("t3_power_e3", 32'h0008);        checkOutput(32'(power));
        tick();
        expectPush("t3_power_off_e4", 32'h0000);    checkOutput(32'(power));
        expectPush("t3_busy_after", 32'h0);         checkOutput(32'(busy));

        // Drive requests without power never reach the board
        doReset();
        applyStimulus(16'h0000, 16'hFFFF);
        nz = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (drive !== '0) nz++;
        end
        expectPush("t4_drive_nonzero_cycles", 32'd0); checkOutput(32'(nz));
        expectPush("t4_power", 32'h0);                checkOutput(32'(power));

        // Asynchronous reset in the middle of a settle
        doReset();
        applyStimulus(16'h0020, 16'h0000);
        waitBusy(1'b1, 20, took);
        expectPush("t5_settle_entry_cycle", 32'd6); checkOutput(32'(took));
        expectPush("t5_power_on", 32'h0020);        checkOutput(32'(power));
        tick(); tick(); tick(); tick();
        expectPush("t5_cur_ch_mid", 32'd5);         checkOutput(32'(cur_ch));
        expectPush("t5_busy_mid", 32'h1);           checkOutput(32'(busy));
        #1 rst = 1'b1;
        #1;
        expectPush("t5_async_power", 32'h0);        checkOutput(32'(power));
        expectPush("t5_async_busy", 32'h0);         checkOutput(32'(busy));
        expectPush("t5_async_cur_ch", 32'h0);       checkOutput(32'(cur_ch));
        @(negedge clk);
        rst = 1'b0;
        waitBusy(1'b1, 20, took);
        expectPush("t5_resequence_cycle", 32'd6);   checkOutput(32'(took));
        expectPush("t5_resequence_ch", 32'd5);      checkOutput(32'(cur_ch));
        expectPush("t5_resequence_power", 32'h0020); checkOutput(32'(power));

        // Request reversed during settle is serviced on the next pass
        doReset();
        applyStimulus(16'h0004, 16'h0000);
        waitBusy(1'b1, 20, took);
        expectPush("t6_settle_entry_cycle", 32'd3); checkOutput(32'(took));
        applyStimulus(16'h0000, 16'h0000);
        waitBusy(1'b0, 20, took);
        expectPush("t6_settle_complete_cycle", 32'd8); checkOutput(32'(took));
        expectPush("t6_power_kept", 32'h0004);      checkOutput(32'(power));
        expectPush("t6_cur_ch_after", 32'd3);       checkOutput(32'(cur_ch));
        took = -1;
        saw_wrap = 0;
        for (int i = 1; i <= 30 && took < 0; i++) begin
            tick();
            if (cur_ch === 4'd0) saw_wrap = 1;
            if (busy === 1'b1) took = i;
        end
        expectPush("t6_drain_entry_cycle", 32'd16); checkOutput(32'(took));
        expectPush("t6_pointer_wrapped", 32'd1);    checkOutput(32'(saw_wrap));
        expectPush("t6_drain_ch", 32'd2);           checkOutput(32'(cur_ch));
        tick(); tick(); tick();
        expectPush("t6_power_e3", 32'h0004);        checkOutput(32'(power));
        tick();
        expectPush("t6_power_off", 32'h0000);       checkOutput(32'(power));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/daughter_power_sequencer.md
DAUGHTER_POWER_SEQUENCER -- requirements
Module: daughter_power_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 16, giving the number of daughterboard rails sequenced (4 types x 4 daughters).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 16'd50000, giving the power-on settle time in clk_i cycles; legal range 1..65535.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 16'd1000, giving the drive-off-to-power-off delay in clk_i cycles; legal range 1..65535.
REQ-004 SHALL have port clk_i, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port power_req_i, input, NUM_CH bits: requested rail power from the power control register.
REQ-007 SHALL have port drive_req_i, input, NUM_CH bits: requested rail drive from the power control register.
REQ-008 SHALL have port power_o, output, NUM_CH bits: registered rail power enables to the board.
REQ-009 SHALL have port drive_o, output, NUM_CH bits: registered rail drive enables to the board.
REQ-010 SHALL have port busy_o, output, 1 bit: high while in SETTLE or DRAIN.
REQ-011 SHALL have port cur_ch_o, output, clog2(NUM_CH) bits: current scan pointer p.

Function
REQ-012 SHALL implement FSM states IDLE, SETTLE, DRAIN, a scan pointer p, a 16-bit down-counter cnt and a NUM_CH-bit settled vector.
REQ-013 SHALL, in IDLE with power_req_i[p]==power_o[p], advance p by one, wrapping NUM_CH-1 -> 0, and stay in IDLE.
REQ-014 SHALL, in IDLE with power_req_i[p]=1 and power_o[p]=0, set power_o[p]=1 and cnt=SETTLE_CYCLES-1 on that edge, and go to SETTLE.
REQ-015 SHALL, in SETTLE, decrement cnt each cycle; at cnt==0 set settled[p]=1, advance p, and return to IDLE.
REQ-016 SHALL, in IDLE with power_req_i[p]=0 and power_o[p]=1, clear settled[p] and set cnt=DRAIN_CYCLES-1 on that edge, and go to DRAIN.
REQ-017 SHALL, in DRAIN, decrement cnt each cycle; at cnt==0 clear power_o[p], advance p, and return to IDLE.
REQ-018 SHALL never abort SETTLE or DRAIN on a request change; a reversed request is serviced on the next pass of p.
REQ-019 SHALL power or unpower at most one rail at a time, limiting inrush.
REQ-020 SHALL register drive_o each cycle as drive_req_i & settled, with settled[i] cleared on the edge entering DRAIN; drive therefore drops one cycle after a request drop or drain start.
REQ-021 SHALL never assert drive_o[i] while power_o[i]=0 or settled[i]=0.
REQ-022 SHALL give turn-on latency from IDLE detection of exactly SETTLE_CYCLES+1 edges to settled[p], plus one edge to drive_o[p].
REQ-023 SHALL give turn-off latency of DRAIN_CYCLES edges from entering DRAIN to power_o[p]=0.
REQ-024 SHALL assert busy_o combinationally from state (SETTLE or DRAIN).

Reset
REQ-025 SHALL, while rst_i=1, force power_o=0, drive_o=0, settled=0, cnt=0, p=0, state=IDLE and busy_o=0, independent of clk_i.
REQ-026 SHALL, on reset asserted mid-SETTLE or mid-DRAIN, drop all rails immediately and resume scanning from p=0 in IDLE after release.

Verification (bench: NUM_CH=16, SETTLE_CYCLES=8, DRAIN_CYCLES=4)
REQ-027 SHALL verify power_req_i=0x0001 and drive_req_i=0x0001 from reset -> power_o[0]=1 on the first edge, busy_o high for 8 cycles, drive_o[0]=1 two edges after settle.
REQ-028 SHALL verify power_req_i=0x8001 set together -> ch0 fully settled before power_o[15] rises; power_o never gains two new bits within one settle window.
REQ-029 SHALL verify that with ch3 on and driven, power_req_i[3] dropped -> drive_o[3]=0 within one edge of DRAIN entry and power_o[3]=0 exactly 4 edges later.
REQ-030 SHALL verify drive_req_i=0xFFFF with power_req_i=0 -> drive_o stays 0x0000 for 100 cycles.
REQ-031 SHALL verify rst_i pulsed at cnt=3 in SETTLE for ch5 -> power_o=0 without a clock edge; after release, ch5 is re-sequenced from p=0.
REQ-032 SHALL verify that power_req_i[2] toggled 1->0 during its SETTLE -> settle completes, p wraps 15 -> 0, then ch2 is drained on the next pass.
